// File: rtl/clk_div_gen_if.sv
// Control/status bundle for clk_div_gen: run request, divisor load handshake
// and the divided clock with its status flags.
interface clk_div_gen_if #(
    parameter int DIV_W = 8
);
    logic             en;
    logic [DIV_W-1:0] div_val;
    logic             div_load;
    logic             clk_out;
    logic             running;
    logic [DIV_W-1:0] cur_div;
    logic             busy;
    logic             div_ack;
    logic             div_err;

    modport master (
        output en, div_val, div_load,
        input  clk_out, running, cur_div, busy, div_ack, div_err
    );

    modport slave (
        input  en, div_val, div_load,
        output clk_out, running, cur_div, busy, div_ack, div_err
    );
endinterface

// File: rtl/clk_div_gen.sv
// Programmable integer clock divider: floor(N/2) high / ceil(N/2) low, whole
// periods only, divisor changes deferred to a period boundary.
module clk_div_gen #(
    parameter int DIV_W   = 8,
    parameter int DEF_DIV = 2
) (
    input  logic          clk_in,
    input  logic          rst,
    clk_div_gen_if.slave  bus
);

    typedef enum logic {
        IDLE,
        RUN
    } state_t;

    state_t           state_q;
    logic [DIV_W-1:0] cnt_q;
    logic [DIV_W-1:0] cur_div_q;
    logic [DIV_W-1:0] pend_q;
    logic             clk_out_q;
    logic             running_q;
    logic             busy_q;
    logic             ack_q;
    logic             err_q;

    logic             at_boundary_d;
    logic [DIV_W-1:0] cnt_d;
    logic [DIV_W-1:0] eff_div_d;
    logic             load_ok_d;
    logic             load_bad_d;

    // NOTE: every always_comb output gets a default first so no path leaves it unassigned (no latch).
    always_comb begin
        at_boundary_d = (state_q == RUN) && (cnt_q == cur_div_q - DIV_W'(1));
        cnt_d         = at_boundary_d ? '0 : cnt_q + DIV_W'(1);
        eff_div_d     = cur_div_q;
        // The period that starts at a boundary already uses the pending divisor.
        if (at_boundary_d && busy_q) begin
            eff_div_d = pend_q;
        end
        load_ok_d  = bus.div_load && (bus.div_val >= DIV_W'(2));
        load_bad_d = bus.div_load && (bus.div_val <  DIV_W'(2));
    end

    // NOTE: state uses non-blocking assignments so every register samples pre-edge values.
    always_ff @(posedge clk_in) begin
        if (rst) begin
            state_q   <= IDLE;
            cnt_q     <= '0;
            cur_div_q <= DIV_W'(DEF_DIV);
            pend_q    <= '0;
            clk_out_q <= 1'b0;
            running_q <= 1'b0;
            busy_q    <= 1'b0;
            ack_q     <= 1'b0;
            err_q     <= 1'b0;
        end else begin
            ack_q <= 1'b0;
            err_q <= 1'b0;
            case (state_q)
                IDLE: begin
                    if (busy_q) begin
                        cur_div_q <= pend_q;
                        busy_q    <= 1'b0;
                        ack_q     <= 1'b1;
                    end
                    if (bus.en) begin
                        state_q   <= RUN;
                        cnt_q     <= '0;
                        clk_out_q <= 1'b1;
                        running_q <= 1'b1;
                    end
                end
                RUN: begin
                    cnt_q     <= cnt_d;
                    clk_out_q <= (cnt_d < (eff_div_d >> 1));
                    if (at_boundary_d) begin
                        if (busy_q) begin
                            cur_div_q <= pend_q;
                            busy_q    <= 1'b0;
                            ack_q     <= 1'b1;
                        end
                        if (!bus.en) begin
                            state_q   <= IDLE;
                            cnt_q     <= '0;
                            clk_out_q <= 1'b0;
                            running_q <= 1'b0;
                        end
                    end
                end
                default: state_q <= IDLE;
            endcase
            // A load on an applying edge is kept for the next boundary (overrides the busy clear).
            if (load_ok_d) begin
                pend_q <= bus.div_val;
                busy_q <= 1'b1;
            end
            if (load_bad_d) begin
                err_q <= 1'b1;
            end
        end
    end

    assign bus.clk_out = clk_out_q;
    assign bus.running = running_q;
    assign bus.cur_div = cur_div_q;
    assign bus.busy    = busy_q;
    assign bus.div_ack = ack_q;
    assign bus.div_err = err_q;

endmodule

// File: tb/tb_clk_div_gen.sv
// Scoreboard bench for clk_div_gen: each stimulus cycle queues the outputs it
// must produce, and they are popped and compared one clk_in edge later.
module tb_clk_div_gen;

    typedef struct {
        logic       co;
        logic       run;
        logic [7:0] div;
        logic       busy;
        logic       ack;
        logic       err;
    } exp_t;

    logic clk_in = 1'b0;
    logic rst    = 1'b1;
    int   n_checks = 0;
    int   n_fail   = 0;
    int   cyc      = 0;
    exp_t sb_q[$];

    clk_div_gen_if #(.DIV_W(8)) bus ();

    clk_div_gen #(.DIV_W(8), .DEF_DIV(2)) dut (
        .clk_in (clk_in),
        .rst    (rst),
        .bus    (bus)
    );

    always #5 clk_in = ~clk_in;

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_checks++;
        if (obs !== exp) begin
            n_fail++;
            $display("FAIL %s cycle=%0d got=%0h expected=%0h", tag, cyc, obs, exp);
        end
    endtask

    // Drive one cycle of inputs, queue what the following edge must produce, then compare.
    task automatic step(input logic en, input logic ld, input logic [7:0] val,
                        input logic co, input logic run, input logic [7:0] div,
                        input logic bsy, input logic ack, input logic err);
        exp_t e;
        bus.en       = en;
        bus.div_load = ld;
        bus.div_val  = val;
        e.co = co; e.run = run; e.div = div; e.busy = bsy; e.ack = ack; e.err = err;
        sb_q.push_back(e);
        @(posedge clk_in);
        #1;
        cyc++;
        e = sb_q.pop_front();
        check("clk_out", 32'(bus.clk_out), 32'(e.co));
        check("running", 32'(bus.running), 32'(e.run));
        check("cur_div", 32'(bus.cur_div), 32'(e.div));
        check("busy",    32'(bus.busy),    32'(e.busy));
        check("div_ack", 32'(bus.div_ack), 32'(e.ack));
        check("div_err", 32'(bus.div_err), 32'(e.err));
    endtask

    // Running cycles with no load: pat lists the expected clk_out, one char per edge.
    task automatic wave(input string pat, input logic en, input logic [7:0] div, input logic bsy);
        for (int i = 0; i < pat.len(); i++) begin
            step(en, 1'b0, 8'd0, (pat[i] == "1"), 1'b1, div, bsy, 1'b0, 1'b0);
        end
    endtask

    initial begin
        #100000;
        $display("FAIL timeout cycle=%0d got=running expected=finished", cyc);
        $fatal(1, "bench timeout");
    end

    initial begin
        bus.en = 1'b0; bus.div_load = 1'b0; bus.div_val = '0;

        // Reset dominates en and div_load.
        rst = 1'b1;
        repeat (4) step(1, 1, 8'd7, 0, 0, 8'd2, 0, 0, 0);
        rst = 1'b0;

        // N=2 from the first enabled edge: 1,0,1,0,1.
        step(1, 0, 8'd0, 1, 1, 8'd2, 0, 0, 0);
        wave("0101", 1, 8'd2, 0);

        // Load 5 mid-period, applied at the next boundary, then 2 high / 3 low.
        step(1, 1, 8'd5, 0, 1, 8'd2, 1, 0, 0);
        step(1, 0, 8'd0, 1, 1, 8'd5, 0, 1, 0);
        wave("100011000", 1, 8'd5, 0);

        // Rejected loads of 0 and 1.
        step(1, 1, 8'd0, 1, 1, 8'd5, 0, 0, 1);
        step(1, 1, 8'd1, 1, 1, 8'd5, 0, 0, 1);
        wave("000", 1, 8'd5, 0);

        // Load on a boundary edge: held for one full period before taking effect.
        step(1, 1, 8'd8, 1, 1, 8'd5, 1, 0, 0);
        wave("1000", 1, 8'd5, 1);
        step(1, 0, 8'd0, 1, 1, 8'd8, 0, 1, 0);
        wave("11", 1, 8'd8, 0);

        // Drop en at cnt=2: period completes 4/4, then IDLE.
        wave("10000", 0, 8'd8, 0);
        step(0, 0, 8'd0, 0, 0, 8'd8, 0, 0, 0);
        step(0, 0, 8'd0, 0, 0, 8'd8, 0, 0, 0);

        // Second run: en dips and returns before the boundary, no stop.
        step(1, 0, 8'd0, 1, 1, 8'd8, 0, 0, 0);
        wave("111", 1, 8'd8, 0);
        wave("00", 0, 8'd8, 0);
        wave("00", 1, 8'd8, 0);
        wave("11110000", 1, 8'd8, 0);

        // Load 6 then 9 back to back: single ack for 9.
        step(1, 1, 8'd6, 1, 1, 8'd8, 1, 0, 0);
        step(1, 1, 8'd9, 1, 1, 8'd8, 1, 0, 0);
        wave("110000", 1, 8'd8, 1);
        step(1, 0, 8'd0, 1, 1, 8'd9, 0, 1, 0);
        wave("111", 1, 8'd9, 0);

        // Reset at cnt=3 truncates everything.
        rst = 1'b1;
        step(1, 0, 8'd0, 0, 0, 8'd2, 0, 0, 0);
        rst = 1'b0;

        // Load in IDLE applies the next cycle.
        step(0, 1, 8'd3, 0, 0, 8'd2, 1, 0, 0);
        step(0, 0, 8'd0, 0, 0, 8'd3, 0, 1, 0);

        // N=3 (1/2), then stop and pending change on the same boundary.
        step(1, 0, 8'd0, 1, 1, 8'd3, 0, 0, 0);
        step(1, 1, 8'd4, 0, 1, 8'd3, 1, 0, 0);
        step(0, 0, 8'd0, 0, 1, 8'd3, 1, 0, 0);
        step(0, 0, 8'd0, 0, 0, 8'd4, 0, 1, 0);
        step(0, 0, 8'd0, 0, 0, 8'd4, 0, 0, 0);

        if (sb_q.size() != 0) begin
            check("sb_drain", 32'(sb_q.size()), 32'd0);
        end
        $display("TB_RESULT checks=%0d failures=%0d", n_checks, n_fail);
        $finish;
    end

endmodule

// File: doc/clk_div_gen.md
CLK_DIV_GEN -- requirements
Module: clk_div_gen

Interface
REQ-001 Parameter DIV_W, default 8, width of divisor bus and internal counter.
REQ-002 Parameter DEF_DIV, default 2, divisor loaded at reset; SHALL be within 2..2^DIV_W-1.
REQ-003 clk_in  input  1  single system clock; all state updates on its rising edge.
REQ-004 rst  input  1  reset, synchronous, active-high.
REQ-005 en  input  1  run request; 1 = generate clk_out, 0 = stop at period end.
REQ-006 div_val  input  DIV_W  requested divisor N, sampled when div_load=1.
REQ-007 div_load  input  1  single-cycle request to change divisor.
REQ-008 clk_out  output  1  registered divided clock.
REQ-009 running  output  1  high while periods are being generated.
REQ-010 cur_div  output  DIV_W  divisor currently in effect.
REQ-011 busy  output  1  a divisor change is pending, not yet applied.
REQ-012 div_ack  output  1  one-cycle pulse on the cycle a new divisor takes effect.
REQ-013 div_err  output  1  one-cycle pulse when a load with div_val<2 is rejected.

Function
REQ-014 Two states, IDLE and RUN; IDLE holds cnt=0, clk_out=0, running=0.
REQ-015 IDLE->RUN on the edge where en=1: cnt<=0, clk_out<=1, running<=1.
REQ-016 In RUN each edge: cnt<=cnt+1, wrapping from cur_div-1 to 0; clk_out<=1 if next cnt < floor(cur_div/2), else 0.
REQ-017 Period = cur_div clk_in cycles; high phase floor(N/2), low phase ceil(N/2) (N=2: 1/1, N=3: 1/2, N=8: 4/4).
REQ-018 Period boundary = edge on which cnt wraps cur_div-1 -> 0.
REQ-019 en=0 in RUN: current period completes; at boundary -> IDLE, clk_out stays 0, no partial pulse ever emitted.
REQ-020 en returning to 1 before the boundary: no stop, no phase disturbance.
REQ-021 div_load with div_val>=2: value stored in pending register, busy<=1 next cycle.
REQ-022 In RUN, pending divisor applied at the next period boundary: cur_div updated, busy<=0, div_ack=1 for that cycle; the new period uses the new divisor from cnt=0.
REQ-023 In IDLE, pending divisor applied the cycle after load: cur_div updated, div_ack pulse, busy<=0.
REQ-024 Load while busy overwrites pending value (last wins); single div_ack for the final value.
REQ-025 div_load with div_val<2: div_err pulse next cycle; pending, busy, cur_div unchanged.
REQ-026 div_load on the same edge as a period boundary: the load is captured; applied at the following boundary, not the current one.
REQ-027 en=0 and div change pending at the same boundary: divisor applied (div_ack) and state -> IDLE on that edge.
REQ-028 cnt width DIV_W; no overflow since cnt < cur_div <= 2^DIV_W-1.

Reset
REQ-029 rst=1 sampled on a clk_in edge: state IDLE, cnt=0, clk_out=0, running=0, cur_div=DEF_DIV, busy=0, div_ack=0, div_err=0, pending cleared.
REQ-030 rst takes priority over en and div_load on the same edge; reset mid-period truncates clk_out to 0 immediately (permitted glitch).
REQ-031 Outputs defined from the first edge with rst=1; no dependence on power-up values afterward.

Verification
REQ-032 Reset 4 cycles with en=1, div_load=1 -> clk_out=0, running=0, cur_div=2, no div_ack.
REQ-033 Release rst, en=1, DEF_DIV=2 -> clk_out toggles 1,0,1,0 from first enabled edge; period 2 cycles.
REQ-034 RUN at N=2, load div_val=5 mid-period -> busy=1, div_ack at next boundary, then clk_out 2 high / 3 low repeating, cur_div=5.
REQ-035 Load 0 then 1 -> two div_err pulses, cur_div unchanged, busy=0.
REQ-036 N=8, drop en at cnt=2 -> clk_out completes 4 high / 4 low, running=0 at boundary; re-raise en at cnt=5 in a second run -> no stop, period continuous.
REQ-037 Load 6 then 9 on consecutive cycles in RUN -> single div_ack, cur_div=9; rst at cnt=3 of a period -> all outputs at reset values next cycle.
